lpm_sched: RTL and testbench
============================

LPM_SCHED -- requirements
Module: lpm_sched

Interface
REQ-001 Parameters (name, default, meaning): DEPTH, 4, max lookups in flight; STEP_W, 4, step-counter width.
REQ-002 CLK  input  1  clock; reset nRST, synchronous, active-low; clock CLK.
REQ-003 nRST  input  1  synchronous active-low reset.
REQ-004 req__ENA in 1 / req_meth in 32 / req_v in 32 / req__RDY out 1 -- new lookup (tag, initial key/address).
REQ-005 cfg_max_steps  input  STEP_W  memory passes per lookup, sampled at admission; value 0 treated as 1.
REQ-006 memreq__ENA out 1 / memreq_v out 32 / memreq__RDY in 1 -- request port of the shared LPM memory.
REQ-007 memres__ENA in 1 / memres_v in 32 / memres__RDY out 1 -- in-order memory response.
REQ-008 done__ENA out 1 / done_meth out 32 / done_v out 32 / done__RDY in 1 -- completed lookup.
REQ-009 inflight out clog2(DEPTH+1) live-context count; done_count out 32 completed lookups; proto_err out 1 sticky error.

Function
REQ-010 Transfer occurs on a port in a cycle iff its __ENA and __RDY are both high; an __ENA SHALL NOT be asserted without the matching __RDY.
REQ-011 Context = {meth, step, max}; contexts SHALL be kept in an in-order context FIFO of DEPTH entries, plus one response-hold register (hold).
REQ-012 Live contexts = FIFO occupancy + hold_valid; inflight SHALL equal this value every cycle.
REQ-013 Memory arbitration, one memreq per cycle, priority: recirculation (from hold) over new admission.
REQ-014 Recirc issue: hold_valid && !hold_final && memreq__RDY -> memreq__ENA=1, memreq_v=hold data, context pushed with step+1, hold cleared, same cycle.
REQ-015 New admission: req__RDY = memreq__RDY && live < DEPTH && !(hold_valid && !hold_final); on transfer memreq__ENA=1, memreq_v=req_v combinationally (zero-cycle latency), context {req_meth, 1, max(cfg_max_steps,1)} pushed.
REQ-016 memres__RDY = !hold_valid || (hold leaves in this cycle); on transfer, FIFO head is popped into hold with data=memres_v; hold_final = (step == max).
REQ-017 Final exit: hold_valid && hold_final -> done__ENA = done__RDY; done_meth=hold meth, done_v=hold data; on transfer hold cleared and done_count increments (wraps 2^32-1 -> 0).
REQ-018 Response-to-done latency: minimum 1 cycle (captured cycle M, done__ENA earliest M+1); recirc reissue likewise earliest M+1.
REQ-019 Simultaneous new admission and memres transfer in the same cycle SHALL both complete; FIFO push and pop in the same cycle SHALL keep occupancy unchanged, including when full.
REQ-020 Full: live == DEPTH -> req__RDY=0; recirculation SHALL still proceed (net-zero occupancy).
REQ-021 Empty: memres__ENA while FIFO empty -> response dropped, memres__RDY stays 1, proto_err set until reset.
REQ-022 done__RDY low holds hold contents stable and back-pressures memres; no context is lost or reordered.
REQ-023 Step arithmetic STEP_W bits; max never exceeds 2^STEP_W-1, so step never wraps.

Reset
REQ-024 While nRST low at a CLK edge: FIFO and hold emptied, done_count=0, proto_err=0; in-flight contexts discarded (memory drained externally).
REQ-025 Output values out of reset: memreq__ENA=0, done__ENA=0, inflight=0, memreq_v/done_meth/done_v=0, memres__RDY=1; req__RDY follows memreq__RDY.

Structure
REQ-026 Shared package lpm_pkg SHALL hold the context typedef, DEPTH and STEP_W defaults, and the 32-bit key/tag widths shared with the LPM datapath.
REQ-027 One sub-module, lpm_ctx_fifo (parameterised synchronous FIFO with simultaneous push/pop), holds contexts; arbitration and hold remain in lpm_sched.

Verification
REQ-028 cfg_max_steps=1, req meth=7 v=0x100, memory returns 0xABC after 3 cycles -> one memreq v=0x100, done meth=7 v=0xABC one cycle after response, done_count=1.
REQ-029 cfg_max_steps=5, one req -> exactly 5 memreq transfers, then one done; inflight=1 throughout until done transfers.
REQ-030 DEPTH=4, 5 back-to-back reqs, memory stalls responses -> 4 admitted, req__RDY=0 for the 5th until first done; done tags in admission order.
REQ-031 Recirc pending while req__ENA held -> memreq carries recirc data, req__RDY=0 that cycle, new req admitted next cycle.
REQ-032 done__RDY=0 for 10 cycles with final hold -> memres__RDY=0, no response lost; releasing gives in-order dones.
REQ-033 memres__ENA with inflight=0 -> proto_err=1 and remains 1; nRST low mid-operation -> inflight=0, done_count=0, proto_err=0.

Source files
------------

// File: rtl/lpm_pkg.sv
// Definitions shared by the LPM lookup scheduler and the LPM datapath:
// key/tag widths, default sizing and the lookup context layout.
package lpm_pkg;
  localparam int LPM_DEPTH  = 4;
  localparam int LPM_STEP_W = 4;
  localparam int LPM_KEY_W  = 32;
  localparam int LPM_TAG_W  = 32;

  typedef struct packed {
    logic [LPM_TAG_W-1:0]  meth;
    logic [LPM_STEP_W-1:0] step;
    logic [LPM_STEP_W-1:0] max_step;
  } lpm_ctx_t;

  // Packed context width for a given step-counter width.
  function automatic int lpm_ctx_bits(input int step_w);
    return LPM_TAG_W + 2 * step_w;
  endfunction
endpackage

// File: rtl/lpm_sched_if.sv
// Handshake bundle around the LPM scheduler: client requests, shared memory
// request/response ports and the completed-lookup port.
interface lpm_sched_if;
  import lpm_pkg::*;

  logic                 req__ENA;
  logic [LPM_TAG_W-1:0] req_meth;
  logic [LPM_KEY_W-1:0] req_v;
  logic                 req__RDY;

  logic                 memreq__ENA;
  logic [LPM_KEY_W-1:0] memreq_v;
  logic                 memreq__RDY;

  logic                 memres__ENA;
  logic [LPM_KEY_W-1:0] memres_v;
  logic                 memres__RDY;

  logic                 done__ENA;
  logic [LPM_TAG_W-1:0] done_meth;
  logic [LPM_KEY_W-1:0] done_v;
  logic                 done__RDY;

  modport master (
    input  req__ENA, req_meth, req_v,
    output req__RDY,
    output memreq__ENA, memreq_v,
    input  memreq__RDY,
    input  memres__ENA, memres_v,
    output memres__RDY,
    output done__ENA, done_meth, done_v,
    input  done__RDY
  );

  modport slave (
    output req__ENA, req_meth, req_v,
    input  req__RDY,
    input  memreq__ENA, memreq_v,
    output memreq__RDY,
    output memres__ENA, memres_v,
    input  memres__RDY,
    input  done__ENA, done_meth, done_v,
    output done__RDY
  );
endinterface

// File: rtl/lpm_ctx_fifo.sv
// In-order context FIFO; push and pop may happen in the same cycle, including
// when full. Head entry is presented combinationally.
module lpm_ctx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop && !empty;
  // A full FIFO accepts a push only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= push_data;
  end
endmodule

// File: rtl/lpm_sched.sv
// LPM lookup scheduler: admits lookups onto the shared memory port, recirculates
// partial results until each lookup has made its passes, then retires it.
module lpm_sched
  import lpm_pkg::*;
#(
  parameter int DEPTH  = LPM_DEPTH,
  parameter int STEP_W = LPM_STEP_W
) (
  input  logic                       CLK,
  input  logic                       nRST,
  lpm_sched_if.master                bus,
  input  logic [STEP_W-1:0]          cfg_max_steps,
  output logic [$clog2(DEPTH+1)-1:0] inflight,
  output logic [31:0]                done_count,
  output logic                       proto_err
);
  localparam int CW    = $clog2(DEPTH+1);
  localparam int CTX_W = lpm_ctx_bits(STEP_W);
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

  typedef struct packed {
    logic [LPM_TAG_W-1:0] meth;
    logic [STEP_W-1:0]    step;
    logic [STEP_W-1:0]    max_step;
  } ctx_t;

  ctx_t                 hold_ctx;
  logic [LPM_KEY_W-1:0] hold_data;
  logic                 hold_valid;
  logic                 hold_final;

  ctx_t                 fifo_head;
  ctx_t                 push_ctx;
  logic [CTX_W-1:0]     head_bits;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [CW-1:0]        live;
  logic [STEP_W-1:0]    adm_max;

  logic recirc;
  logic exit_fire;
  logic hold_leaves;
  logic admit;
  logic push;
  logic res_fire;
  logic res_take;
  logic res_drop;
  logic show_done;

  assign live = fifo_count + CW'(hold_valid);

  // Recirculation owns the memory port whenever a partial result is waiting.
  assign recirc      = hold_valid && !hold_final && bus.memreq__RDY;
  assign exit_fire   = hold_valid && hold_final && bus.done__RDY;
  assign hold_leaves = recirc || exit_fire;

  assign bus.req__RDY = bus.memreq__RDY && (live < DEPTH_C) && !(hold_valid && !hold_final);
  assign admit        = bus.req__ENA && bus.req__RDY;

  assign bus.memreq__ENA = recirc || admit;
  assign bus.memreq_v    = recirc ? hold_data : (admit ? bus.req_v : '0);

  assign bus.memres__RDY = !hold_valid || hold_leaves;
  assign res_fire        = bus.memres__ENA && bus.memres__RDY;
  assign res_take        = res_fire && !fifo_empty;
  assign res_drop        = res_fire && fifo_empty;

  assign show_done     = hold_valid && hold_final;
  assign bus.done__ENA = exit_fire;
  assign bus.done_meth = show_done ? hold_ctx.meth : '0;
  assign bus.done_v    = show_done ? hold_data : '0;

  assign adm_max = (cfg_max_steps == '0) ? STEP_ONE : cfg_max_steps;
  assign push    = recirc || admit;

  always_comb begin
    push_ctx = '0;
    if (recirc) begin
      push_ctx      = hold_ctx;
      push_ctx.step = hold_ctx.step + STEP_ONE;
    end else begin
      push_ctx.meth     = bus.req_meth;
      push_ctx.step     = STEP_ONE;
      push_ctx.max_step = adm_max;
    end
  end

  lpm_ctx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CTX_W)
  ) u_ctx_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .push      (push),
    .push_data (push_ctx),
    .pop       (res_take),
    .head      (head_bits),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign fifo_head = ctx_t'(head_bits);

  // A response may refill hold in the same cycle its previous occupant leaves.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hold_valid <= 1'b0;
      hold_final <= 1'b0;
      hold_ctx   <= '0;
      hold_data  <= '0;
    end else if (res_take) begin
      hold_valid <= 1'b1;
      hold_final <= (fifo_head.step == fifo_head.max_step);
      hold_ctx   <= fifo_head;
      hold_data  <= bus.memres_v;
    end else if (hold_leaves) begin
      hold_valid <= 1'b0;
      hold_final <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      done_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (exit_fire) done_count <= done_count + 32'd1;
      if (res_drop)  proto_err  <= 1'b1;
    end
  end

  assign inflight = live;
endmodule

// File: tb/tb_lpm_sched.sv
// Randomized bench for lpm_sched: a bench-side memory answers every request
// with v + K, so a lookup of n passes must finish with v + n*K.
`timescale 1ns/1ps
module tb_lpm_sched;
  import lpm_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STEP_W = 4;
  localparam logic [31:0] K = 32'h0000_09BC;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [STEP_W-1:0] cfg_max_steps;
  logic [2:0]        inflight;
  logic [31:0]       done_count;
  logic              proto_err;

  lpm_sched_if bus();

  lpm_sched #(.DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .bus           (bus),
    .cfg_max_steps (cfg_max_steps),
    .inflight      (inflight),
    .done_count    (done_count),
    .proto_err     (proto_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] memq_v[$];
  int          memq_t[$];
  logic [31:0] pend_meth[$];
  logic [31:0] pend_v[$];
  logic [31:0] exp_v[logic [31:0]];
  logic [31:0] done_tags[$];
  int          done_cycs[$];
  int          admit_cyc[$];
  int n_admit, n_done, n_memreq, n_res, dc_model, sum_eff;
  int res_cyc, done_cyc;
  int mem_lat = 1, p_mrdy = 100, p_drdy = 100;
  bit mem_stall = 0, rand_cfg = 0;
  logic        obs_req_rdy, obs_recirc, obs_memres_rdy;
  logic [31:0] obs_memreq_v, last_done_v;

  task automatic clear_model();
    memq_v.delete(); memq_t.delete(); pend_meth.delete(); pend_v.delete();
    exp_v.delete(); done_tags.delete(); done_cycs.delete(); admit_cyc.delete();
    n_admit = 0; n_done = 0; n_memreq = 0; n_res = 0; dc_model = 0; sum_eff = 0;
    res_cyc = 0; done_cyc = 0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    bus.req__ENA = 1'b0; bus.req_meth = '0; bus.req_v = '0;
    bus.memres__ENA = 1'b0; bus.memres_v = '0;
    bus.memreq__RDY = 1'b1; bus.done__RDY = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    clear_model();
  endtask

  // One clock of bench-side client, memory and done sink, plus model checks.
  task automatic tick();
    int lat;
    logic [STEP_W-1:0] eff;
    logic [31:0] t;
    @(negedge CLK);
    bus.memreq__RDY = (int'($urandom_range(99)) < p_mrdy);
    bus.done__RDY   = (int'($urandom_range(99)) < p_drdy);
    if (rand_cfg) cfg_max_steps = STEP_W'($urandom_range(15));
    #1;
    bus.req__ENA   = (pend_meth.size() > 0) && bus.req__RDY;
    bus.req_meth   = (pend_meth.size() > 0) ? pend_meth[0] : 32'd0;
    bus.req_v      = (pend_v.size() > 0) ? pend_v[0] : 32'd0;
    bus.memres__ENA = !mem_stall && (memq_v.size() > 0) && (memq_t[0] <= cyc) && bus.memres__RDY;
    bus.memres_v    = (memq_v.size() > 0) ? memq_v[0] + K : 32'd0;
    #1;
    checks++;
    if (int'(inflight) != n_admit - n_done) begin
      errors++; $display("FAIL inflight cyc %0d got %0d exp %0d", cyc, inflight, n_admit - n_done);
    end
    checks++;
    if (done_count !== 32'(dc_model)) begin
      errors++; $display("FAIL done_count cyc %0d got %0d exp %0d", cyc, done_count, dc_model);
    end
    if (bus.memreq__ENA && !bus.memreq__RDY) begin
      errors++; $display("FAIL memreq_ena_without_rdy cyc %0d got 1 exp 0", cyc);
    end
    if (bus.done__ENA && !bus.done__RDY) begin
      errors++; $display("FAIL done_ena_without_rdy cyc %0d got 1 exp 0", cyc);
    end
    obs_req_rdy    = bus.req__RDY;
    obs_memres_rdy = bus.memres__RDY;
    obs_recirc     = bus.memreq__ENA && !(bus.req__ENA && bus.req__RDY);
    obs_memreq_v   = bus.memreq_v;
    if (bus.req__ENA && bus.req__RDY && !bus.memreq__ENA) begin
      errors++; $display("FAIL admit_no_memreq cyc %0d got 0 exp 1", cyc);
    end
    if (bus.memreq__ENA) begin
      n_memreq++;
      lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(4, 1));
      memq_v.push_back(bus.memreq_v);
      memq_t.push_back(cyc + lat);
      if (bus.req__ENA && bus.req__RDY) begin
        checks++;
        if (bus.memreq_v !== pend_v[0]) begin
          errors++; $display("FAIL admit_v cyc %0d got %h exp %h", cyc, bus.memreq_v, pend_v[0]);
        end
        eff = (cfg_max_steps == '0) ? STEP_W'(1) : cfg_max_steps;
        exp_v[pend_meth[0]] = pend_v[0] + K * 32'(eff);
        sum_eff += int'(eff);
        admit_cyc.push_back(cyc);
        void'(pend_meth.pop_front());
        void'(pend_v.pop_front());
        n_admit++;
      end
    end
    if (bus.memres__ENA) begin
      void'(memq_v.pop_front());
      void'(memq_t.pop_front());
      n_res++;
      res_cyc = cyc;
    end
    if (bus.done__ENA && bus.done__RDY) begin
      t = bus.done_meth;
      checks++;
      if (!exp_v.exists(t)) begin
        errors++; $display("FAIL done_tag cyc %0d got %0d exp a live tag", cyc, t);
      end else begin
        if (bus.done_v !== exp_v[t]) begin
          errors++; $display("FAIL done_v tag %0d got %h exp %h", t, bus.done_v, exp_v[t]);
        end
        exp_v.delete(t);
      end
      last_done_v = bus.done_v;
      done_tags.push_back(t);
      done_cycs.push_back(cyc);
      n_done++; dc_model++;
      done_cyc = cyc;
    end
    @(posedge CLK);
    cyc++;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    bus.memreq__RDY = 1'b0; #1;
    checks++; if (bus.req__RDY !== 1'b0) begin errors++; $display("FAIL reset_req_rdy_lo got %b exp 0", bus.req__RDY); end
    bus.memreq__RDY = 1'b1; #1;
    checks++; if (bus.req__RDY !== 1'b1) begin errors++; $display("FAIL reset_req_rdy_hi got %b exp 1", bus.req__RDY); end
    checks++; if (bus.memreq__ENA !== 1'b0) begin errors++; $display("FAIL reset_memreq_ena got %b exp 0", bus.memreq__ENA); end
    checks++; if (bus.done__ENA !== 1'b0) begin errors++; $display("FAIL reset_done_ena got %b exp 0", bus.done__ENA); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
    checks++; if (bus.memreq_v !== 32'd0) begin errors++; $display("FAIL reset_memreq_v got %h exp 0", bus.memreq_v); end
    checks++; if (bus.done_meth !== 32'd0 || bus.done_v !== 32'd0) begin
      errors++; $display("FAIL reset_done_data got %h/%h exp 0/0", bus.done_meth, bus.done_v);
    end
    checks++; if (bus.memres__RDY !== 1'b1) begin errors++; $display("FAIL reset_memres_rdy got %b exp 1", bus.memres__RDY); end
    checks++; if (done_count !== 32'd0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL reset_counters got %0d/%b exp 0/0", done_count, proto_err);
    end
  endtask

  task automatic test_single();
    int m0, d0;
    p_mrdy = 100; p_drdy = 100; mem_lat = 3; rand_cfg = 0; mem_stall = 0;
    cfg_max_steps = 4'd1;
    m0 = n_memreq; d0 = n_done;
    pend_meth.push_back(32'd7); pend_v.push_back(32'h100);
    for (int i = 0; i < 30 && n_done < d0 + 1; i++) tick();
    checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL single_timeout got %0d exp %0d", n_done, d0 + 1); end
    checks++; if (n_memreq - m0 != 1) begin errors++; $display("FAIL single_memreqs got %0d exp 1", n_memreq - m0); end
    checks++; if (last_done_v !== 32'hABC) begin errors++; $display("FAIL single_done_v got %h exp abc", last_done_v); end
    checks++; if (done_tags.size() != d0 + 1 || done_tags[d0] !== 32'd7) begin
      errors++; $display("FAIL single_done_meth got %0d exp 7", done_tags.size() > d0 ? done_tags[d0] : 32'hFFFF_FFFF);
    end
    checks++; if (done_cyc - res_cyc != 1) begin errors++; $display("FAIL single_latency got %0d exp 1", done_cyc - res_cyc); end
    #2;
    checks++; if (done_count !== 32'd1) begin errors++; $display("FAIL single_done_count got %0d exp 1", done_count); end
    // zero passes configured behaves as one pass
    cfg_max_steps = 4'd0;
    m0 = n_memreq; d0 = n_done;
    pend_meth.push_back(32'd8); pend_v.push_back(32'h200);
    for (int i = 0; i < 30 && n_done < d0 + 1; i++) tick();
    checks++; if (n_memreq - m0 != 1) begin errors++; $display("FAIL cfg0_memreqs got %0d exp 1", n_memreq - m0); end
    checks++; if (last_done_v !== 32'h200 + K) begin errors++; $display("FAIL cfg0_done_v got %h exp %h", last_done_v, 32'h200 + K); end
  endtask

  task automatic test_multi_step();
    int m0, d0;
    cfg_max_steps = 4'd5; mem_lat = 2;
    m0 = n_memreq; d0 = n_done;
    pend_meth.push_back(32'd9); pend_v.push_back(32'h1234);
    for (int i = 0; i < 60 && n_done < d0 + 1; i++) tick();
    checks++; if (n_done != d0 + 1) begin errors++; $display("FAIL multi_timeout got %0d exp %0d", n_done, d0 + 1); end
    checks++; if (n_memreq - m0 != 5) begin errors++; $display("FAIL multi_memreqs got %0d exp 5", n_memreq - m0); end
    checks++; if (last_done_v !== 32'h1234 + 5 * K) begin errors++; $display("FAIL multi_done_v got %h exp %h", last_done_v, 32'h1234 + 5 * K); end
    #2;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL multi_inflight_after got %0d exp 0", inflight); end
  endtask

  task automatic test_full();
    int a0, d0;
    cfg_max_steps = 4'd1; mem_lat = 1; mem_stall = 1;
    a0 = n_admit; d0 = n_done;
    for (int i = 0; i < 5; i++) begin
      pend_meth.push_back(32'(20 + i)); pend_v.push_back($urandom);
    end
    repeat (12) tick();
    checks++; if (n_admit - a0 != 4) begin errors++; $display("FAIL full_admitted got %0d exp 4", n_admit - a0); end
    checks++; if (obs_req_rdy !== 1'b0) begin errors++; $display("FAIL full_req_rdy got %b exp 0", obs_req_rdy); end
    #2;
    checks++; if (inflight !== 3'd4) begin errors++; $display("FAIL full_inflight got %0d exp 4", inflight); end
    mem_stall = 0;
    for (int i = 0; i < 80 && n_done < d0 + 5; i++) tick();
    checks++; if (n_done != d0 + 5) begin errors++; $display("FAIL full_timeout got %0d exp %0d", n_done, d0 + 5); end
    for (int i = 0; i < 5 && n_done == d0 + 5; i++) begin
      checks++;
      if (done_tags[d0 + i] !== 32'(20 + i)) begin
        errors++; $display("FAIL full_order idx %0d got %0d exp %0d", i, done_tags[d0 + i], 20 + i);
      end
    end
    if (n_done == d0 + 5) begin
      checks++;
      if (admit_cyc[a0 + 4] <= done_cycs[d0]) begin
        errors++; $display("FAIL full_fifth_admit got cyc %0d exp after %0d", admit_cyc[a0 + 4], done_cycs[d0]);
      end
    end
  endtask

  task automatic test_recirc_priority();
    int a0, r0, d0;
    cfg_max_steps = 4'd2; mem_lat = 1;
    a0 = n_admit; r0 = n_res; d0 = n_done;
    pend_meth.push_back(32'd30); pend_v.push_back(32'h3000);
    for (int i = 0; i < 20 && n_res < r0 + 1; i++) tick();
    pend_meth.push_back(32'd31); pend_v.push_back(32'h3100);
    tick();
    checks++; if (obs_recirc !== 1'b1) begin errors++; $display("FAIL recirc_issue got %b exp 1", obs_recirc); end
    checks++; if (obs_memreq_v !== 32'h3000 + K) begin errors++; $display("FAIL recirc_v got %h exp %h", obs_memreq_v, 32'h3000 + K); end
    checks++; if (obs_req_rdy !== 1'b0) begin errors++; $display("FAIL recirc_req_rdy got %b exp 0", obs_req_rdy); end
    tick();
    checks++; if (n_admit != a0 + 2) begin errors++; $display("FAIL recirc_next_admit got %0d exp %0d", n_admit - a0, 2); end
    for (int i = 0; i < 60 && n_done < d0 + 2; i++) tick();
    checks++; if (n_done != d0 + 2) begin errors++; $display("FAIL recirc_timeout got %0d exp %0d", n_done, d0 + 2); end
  endtask

  task automatic test_backpressure();
    int r0, d0;
    cfg_max_steps = 4'd1; mem_lat = 1; p_drdy = 0;
    r0 = n_res; d0 = n_done;
    for (int i = 0; i < 3; i++) begin
      pend_meth.push_back(32'(40 + i)); pend_v.push_back($urandom);
    end
    repeat (12) tick();
    checks++; if (obs_memres_rdy !== 1'b0) begin errors++; $display("FAIL bp_memres_rdy got %b exp 0", obs_memres_rdy); end
    checks++; if (n_res != r0 + 1 || n_done != d0) begin
      errors++; $display("FAIL bp_counts got res %0d done %0d exp 1/0", n_res - r0, n_done - d0);
    end
    p_drdy = 100;
    for (int i = 0; i < 40 && n_done < d0 + 3; i++) tick();
    checks++; if (n_done != d0 + 3) begin errors++; $display("FAIL bp_timeout got %0d exp %0d", n_done, d0 + 3); end
    for (int i = 0; i < 3 && n_done == d0 + 3; i++) begin
      checks++;
      if (done_tags[d0 + i] !== 32'(40 + i)) begin
        errors++; $display("FAIL bp_order idx %0d got %0d exp %0d", i, done_tags[d0 + i], 40 + i);
      end
    end
  endtask

  task automatic test_proto_err();
    @(negedge CLK);
    bus.req__ENA = 1'b0; bus.memreq__RDY = 1'b1; bus.done__RDY = 1'b1;
    bus.memres__ENA = 1'b1; bus.memres_v = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus.memres__RDY !== 1'b1) begin errors++; $display("FAIL perr_memres_rdy got %b exp 1", bus.memres__RDY); end
    @(posedge CLK); cyc++;
    #2;
    bus.memres__ENA = 1'b0;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got %b exp 1", proto_err); end
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL perr_inflight got %0d exp 0", inflight); end
    repeat (5) tick();
    #2;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %b exp 1", proto_err); end
    // reset while lookups are in flight
    cfg_max_steps = 4'd3; mem_lat = 2;
    for (int i = 0; i < 3; i++) begin
      pend_meth.push_back(32'(50 + i)); pend_v.push_back($urandom);
    end
    repeat (5) tick();
    do_reset();
    #2;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rst_inflight got %0d exp 0", inflight); end
    checks++; if (done_count !== 32'd0) begin errors++; $display("FAIL rst_done_count got %0d exp 0", done_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b exp 0", proto_err); end
  endtask

  task automatic test_random();
    do_reset();
    rand_cfg = 1; p_mrdy = 70; p_drdy = 70; mem_lat = 0; mem_stall = 0;
    for (int i = 0; i < 40; i++) begin
      pend_meth.push_back(32'(100 + i)); pend_v.push_back($urandom);
    end
    for (int i = 0; i < 5000 && n_done < 40; i++) tick();
    rand_cfg = 0;
    checks++; if (n_done != 40) begin errors++; $display("FAIL rand_timeout got %0d exp 40", n_done); end
    checks++; if (exp_v.size() != 0) begin errors++; $display("FAIL rand_lost got %0d exp 0", exp_v.size()); end
    checks++; if (n_memreq != sum_eff) begin errors++; $display("FAIL rand_memreqs got %0d exp %0d", n_memreq, sum_eff); end
    #2;
    checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL rand_inflight got %0d exp 0", inflight); end
    checks++; if (done_count !== 32'd40) begin errors++; $display("FAIL rand_done_count got %0d exp 40", done_count); end
  endtask

  initial begin
    nRST = 1'b0;
    cfg_max_steps = 4'd1;
    clear_model();
    test_reset();
    test_single();
    test_multi_step();
    test_full();
    test_recirc_priority();
    test_backpressure();
    test_proto_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
